wide_word_fifo: RTL and testbench



---
 rtl/wide_word_fifo.sv | 78 +++++++
 tb/tb_wide_word_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wide_word_fifo.sv
// wide_word_fifo: single-clock multi-lane FIFO with shared pointers, status flags and optional FWFT read
module wide_word_fifo #(
  parameter int NUM_LANES = 2,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_LEVEL  = DEPTH - 1,
  parameter int AE_LEVEL  = 1,
  parameter int FWFT      = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           write_en,
  input  logic                           read_en,
  input  logic [NUM_LANES*WIDTH-1:0]     data_in,
  output logic [NUM_LANES*WIDTH-1:0]     data_out,
  output logic                           read_valid,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           overflow,
  output logic                           underflow
);
  localparam int DW = NUM_LANES * WIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          rvalid_q, rvalid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic          do_wr, do_rd;
  assign full         = count_q == CW'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CW'(AF_LEVEL);
  assign almost_empty = count_q <= CW'(AE_LEVEL);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign data_out     = (FWFT != 0) ? (empty ? '0 : mem[rd_ptr_q]) : dout_q;
  assign read_valid   = (FWFT != 0) ? !empty : rvalid_q;
  // clear overrides both requests, so neither is accepted in a clear cycle
  assign do_wr = write_en && !full && !clear;
  assign do_rd = read_en && !empty && !clear;
  always_comb begin
    wr_ptr_d = clear ? '0 : do_wr ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = clear ? '0 : do_rd ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = clear ? '0 : count_q + CW'(do_wr) - CW'(do_rd);
    dout_d   = clear ? '0 : do_rd ? mem[rd_ptr_q] : dout_q;
    rvalid_d = do_rd;
    ovf_d    = !clear && (ovf_q || (write_en && full));
    unf_d    = !clear && (unf_q || (read_en && empty));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= data_in;
  end
endmodule

// File: tb/tb_wide_word_fifo.sv
// tb_wide_word_fifo: directed checks of wide_word_fifo in registered-read and FWFT modes
module tb_wide_word_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0, write_en = 1'b0, read_en = 1'b0;
  logic [15:0] data_in = '0, data_out;
  logic        read_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0]  count;
  logic        clear1 = 1'b0, w1 = 1'b0, r1 = 1'b0;
  logic [15:0] d1 = '0, q1;
  logic        rv1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0]  cnt1;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  wide_word_fifo #(.NUM_LANES(2), .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .data_out(data_out), .read_valid(read_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow));
  wide_word_fifo #(.NUM_LANES(2), .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .write_en(w1), .read_en(r1),
    .data_in(d1), .data_out(q1), .read_valid(rv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(unf1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, " count"}, 32'(count), 0);
    chk({tag, " empty"}, 32'(empty), 1);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " almost_empty"}, 32'(almost_empty), 1);
    chk({tag, " almost_full"}, 32'(almost_full), 0);
    chk({tag, " data_out"}, 32'(data_out), 0);
    chk({tag, " read_valid"}, 32'(read_valid), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
    chk({tag, " underflow"}, 32'(underflow), 0);
  endtask
  logic [15:0] wv [4] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
  logic        ae_e [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic        af_e [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic        fu_e [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  initial begin
    #2;
    chk_reset_state("reset");
    chk("fwft reset read_valid", 32'(rv1), 0);
    #10 rst_n = 1'b1;
    // test 1: fill to full, then overflow
    for (int i = 0; i < 4; i++) begin
      write_en = 1'b1; data_in = wv[i];
      tick();
      chk($sformatf("t1 count w%0d", i), 32'(count), 32'(i + 1));
      chk($sformatf("t1 almost_empty w%0d", i), 32'(almost_empty), 32'(ae_e[i]));
      chk($sformatf("t1 almost_full w%0d", i), 32'(almost_full), 32'(af_e[i]));
      chk($sformatf("t1 full w%0d", i), 32'(full), 32'(fu_e[i]));
    end
    data_in = 16'hFFFF;
    tick();
    write_en = 1'b0;
    chk("t1 overflow", 32'(overflow), 1);
    chk("t1 count after overflow", 32'(count), 4);
    chk("t1 empty", 32'(empty), 0);
    // test 2: drain in order, then underflow
    for (int i = 0; i < 4; i++) begin
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      chk($sformatf("t2 data r%0d", i), 32'(data_out), 32'(wv[i]));
      chk($sformatf("t2 read_valid r%0d", i), 32'(read_valid), 1);
      chk($sformatf("t2 count r%0d", i), 32'(count), 32'(3 - i));
      tick();
      chk($sformatf("t2 read_valid idle r%0d", i), 32'(read_valid), 0);
      chk($sformatf("t2 data hold r%0d", i), 32'(data_out), 32'(wv[i]));
    end
    chk("t2 empty", 32'(empty), 1);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("t2 underflow", 32'(underflow), 1);
    chk("t2 read_valid on underflow", 32'(read_valid), 0);
    chk("t2 data hold after underflow", 32'(data_out), 16'h0718);
    chk("t2 overflow still sticky", 32'(overflow), 1);
    // test 3: steady simultaneous traffic at count=2
    write_en = 1'b1;
    data_in = 16'h0100; tick();
    data_in = 16'h0101; tick();
    read_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 16'h0102 + 16'(i);
      tick();
      chk($sformatf("t3 data %0d", i), 32'(data_out), 32'(16'h0100 + 16'(i)));
      chk($sformatf("t3 count %0d", i), 32'(count), 2);
      chk($sformatf("t3 read_valid %0d", i), 32'(read_valid), 1);
    end
    read_en = 1'b0;
    // test 4: clear overrides write and read
    data_in = 16'h0A0A;
    tick();
    chk("t4 count before clear", 32'(count), 3);
    clear = 1'b1; read_en = 1'b1; data_in = 16'hDEAD;
    tick();
    clear = 1'b0; read_en = 1'b0; write_en = 1'b0;
    chk_reset_state("t4 clear");
    write_en = 1'b1; data_in = 16'h0B0B;
    tick();
    write_en = 1'b0; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("t4 data after clear", 32'(data_out), 16'h0B0B);
    chk("t4 empty after clear", 32'(empty), 1);
    // test 5: asynchronous reset mid-cycle with count=3
    write_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 16'h5151 + 16'(i) * 16'h0101;
      tick();
    end
    write_en = 1'b0; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("t5 count before reset", 32'(count), 3);
    chk("t5 data before reset", 32'(data_out), 16'h5151);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("t5 async");
    @(negedge clk);
    rst_n = 1'b1;
    write_en = 1'b1; data_in = 16'h7777;
    tick();
    write_en = 1'b0; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("t5 data after reset", 32'(data_out), 16'h7777);
    chk("t5 read_valid after reset", 32'(read_valid), 1);
    chk("t5 count after reset", 32'(count), 0);
    // test 6: FWFT instance
    chk("t6 initial data", 32'(q1), 0);
    chk("t6 initial empty", 32'(empty1), 1);
    w1 = 1'b1; d1 = 16'h1234;
    tick();
    w1 = 1'b0;
    chk("t6 fwft data", 32'(q1), 16'h1234);
    chk("t6 fwft read_valid", 32'(rv1), 1);
    tick();
    chk("t6 fwft data held", 32'(q1), 16'h1234);
    r1 = 1'b1;
    tick();
    r1 = 1'b0;
    chk("t6 data after pop", 32'(q1), 0);
    chk("t6 empty after pop", 32'(empty1), 1);
    chk("t6 read_valid after pop", 32'(rv1), 0);
    w1 = 1'b1; d1 = 16'h5678; tick();
    d1 = 16'h9ABC; tick();
    w1 = 1'b0; r1 = 1'b1;
    tick();
    r1 = 1'b0;
    chk("t6 next head", 32'(q1), 16'h9ABC);
    chk("t6 count", 32'(cnt1), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
